// File: rtl/booth_ctrl_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier controller.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    SHIFT,
    DONE
  } booth_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Returns {ld_a, add_sub} for the current Booth bit pair.
  function automatic logic [1:0] booth_decode(input logic q0, input logic qm1);
    logic [1:0] res;
    res = {1'b0, OP_ADD};
    case ({q0, qm1})
      2'b10:   res = {1'b1, OP_SUB};
      2'b01:   res = {1'b1, OP_ADD};
      default: res = {1'b0, OP_ADD};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/booth_ctrl_if.sv
// Requester/datapath-facing bundle of the Booth controller; slave = controller.
interface booth_ctrl_if #(
  parameter int unsigned WIDTH = 5
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic             q0;
  logic             qm1;
  logic             clr_a;
  logic             ld_m;
  logic             ld_q;
  logic             clr_qm1;
  logic             ld_a;
  logic             add_sub;
  logic             shift;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;

  modport master (
    output start, q0, qm1,
    input  clr_a, ld_m, ld_q, clr_qm1, ld_a, add_sub, shift, busy, done, cnt
  );

  modport slave (
    input  start, q0, qm1,
    output clr_a, ld_m, ld_q, clr_qm1, ld_a, add_sub, shift, busy, done, cnt
  );
endinterface

// File: rtl/booth_ctrl_iter_cnt.sv
// Booth iteration counter: sync clear/increment, flags the last iteration.
module booth_iter_cnt #(
  parameter int unsigned WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           inc,
  output logic [$clog2(WIDTH+1)-1:0]     cnt,
  output logic                           term
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier control FSM driving the A/Q/Q-1 datapath strobes.
// Define BOOTH_CTRL_BACK2BACK_EN to let start in DONE re-enter INIT directly.
module booth_ctrl #(
  parameter int unsigned WIDTH = 5
) (
  input logic         clk,
  input logic         rst,
  booth_ctrl_if.slave bus
);
  import booth_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  booth_state_t     state_q, state_d;
  logic             init_q, init_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_inc, cnt_term;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       dec;

  booth_iter_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .term (cnt_term)
  );

  assign cnt_clr = (state_q == INIT);
  assign cnt_inc = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = INIT;
      INIT:  state_d = CHECK;
      CHECK: state_d = SHIFT;
      SHIFT: state_d = cnt_term ? DONE : CHECK;
`ifdef BOOTH_CTRL_BACK2BACK_EN
      DONE:  state_d = bus.start ? INIT : IDLE;
`else
      DONE:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs are decoded from the next state so the flops line up with state_q.
  always_comb begin
    init_d  = (state_d == INIT);
    shift_d = (state_d == SHIFT);
    busy_d  = (state_d == INIT) || (state_d == CHECK) || (state_d == SHIFT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The add/sub strobes follow q0/qm1 combinationally while in CHECK.
  always_comb begin
    dec = 2'b00;
    if (state_q == CHECK) begin
      dec = booth_decode(bus.q0, bus.qm1);
    end
  end

  assign bus.clr_a   = init_q;
  assign bus.ld_m    = init_q;
  assign bus.ld_q    = init_q;
  assign bus.clr_qm1 = init_q;
  assign bus.ld_a    = dec[1];
  assign bus.add_sub = dec[0];
  assign bus.shift   = shift_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cnt     = cnt;

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench for booth_ctrl with a behavioural A/Q/Q-1 datapath model.
module tb_booth_ctrl;
  localparam int unsigned W = 5;
  localparam int unsigned LAST = 2 * W + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  booth_ctrl_if #(.WIDTH(W)) bus ();

  booth_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Datapath model: A carries one guard bit so the shifted-in sign is the true sum sign.
  logic signed [W:0] a_r;
  logic [W-1:0]      q_r, m_r, m_in, q_in;
  logic              qm1_r;
  logic              force_en = 1'b0;
  logic              f_q0 = 1'b0, f_qm1 = 1'b0;

  assign bus.q0  = force_en ? f_q0  : q_r[0];
  assign bus.qm1 = force_en ? f_qm1 : qm1_r;

  always @(posedge clk) begin
    if (bus.clr_a)   a_r   <= '0;
    if (bus.ld_m)    m_r   <= m_in;
    if (bus.ld_q)    q_r   <= q_in;
    if (bus.clr_qm1) qm1_r <= 1'b0;
    if (bus.ld_a)
      a_r <= bus.add_sub ? a_r - $signed({m_r[W-1], m_r}) : a_r + $signed({m_r[W-1], m_r});
    else if (bus.shift)
      {a_r, q_r, qm1_r} <= {a_r[W], a_r, q_r};
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("excl_lda_shift", 32'(bus.ld_a & bus.shift), 32'd0);
      check("excl_busy_done", 32'(bus.busy & bus.done), 32'd0);
    end
  end

  int held_cnt = 0;

  function automatic logic [8:0] outs();
    return {bus.clr_a, bus.ld_m, bus.ld_q, bus.clr_qm1, bus.ld_a, bus.add_sub,
            bus.shift, bus.busy, bus.done};
  endfunction

  // Expected controller view k cycles after the start-sampling edge.
  task automatic check_cycle(input int k);
    logic init, chk, shf, dn, la, as;
    init = (k == 0);
    chk  = (k >= 1) && (k <= 2 * W - 1) && (k % 2 == 1);
    shf  = (k >= 2) && (k <= 2 * W) && (k % 2 == 0);
    dn   = (k == LAST);
    la = 1'b0;
    as = 1'b0;
    if (chk) begin
      if (bus.q0 && !bus.qm1)      begin la = 1'b1; as = 1'b1; end
      else if (!bus.q0 && bus.qm1) begin la = 1'b1; as = 1'b0; end
    end
    check($sformatf("strobes_k%0d", k), 32'(outs()),
          32'({init, init, init, init, la, as, shf, init | chk | shf, dn}));
    check($sformatf("cnt_k%0d", k), 32'(bus.cnt), (k == 0) ? 32'(held_cnt) : 32'((k - 1) / 2));
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'(outs()), 32'd0);
  endtask

  task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] q, input bit hold);
    int pm;
    logic [2*W-1:0] exp_p;
    pm    = int'($signed(m)) * int'($signed(q));
    exp_p = pm[2*W-1:0];
    m_in  = m;
    q_in  = q;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= int'(LAST); k++) begin
      if (!hold || k == int'(LAST)) bus.start = 1'b0;
      check_cycle(k);
      if (k == int'(LAST) && !force_en)
        check("product", 32'({a_r[W-1:0], q_r}), 32'(exp_p));
      @(posedge clk); #1;
    end
    held_cnt = W;
    check_idle("idle_after_done");
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int c0, c1;
    logic [2*W-1:0] ex;
    bus.start = 1'b0;
    m_in = '0;
    q_in = '0;
    #1 rst = 1'b1;
    #2;
    check_idle("reset_outs");
    check("reset_cnt", 32'(bus.cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    check_idle("post_reset_outs");

    // Spec examples
    run_mul(5'd6, 5'b11101, 1'b0);
    ex = 10'b1111101110;
    check("ex_6x_m3", 32'({a_r[W-1:0], q_r}), 32'(ex));
    run_mul(5'b10000, 5'b10000, 1'b0);
    check("ex_m16x_m16", 32'({a_r[W-1:0], q_r}), 32'd256);

    // Decode table with the bit pair forced while in CHECK
    force_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      {f_q0, f_qm1} = 2'(p);
      run_mul('0, '0, 1'b0);
    end
    force_en = 1'b0;

    // start held through a whole multiply: single INIT, single done
    run_mul(5'd11, 5'd13, 1'b1);

    // Back-to-back spacing with start held
    bus.start = 1'b1;
    wait_done(c0);
    @(posedge clk); #1;
    wait_done(c1);
`ifdef BOOTH_CTRL_BACK2BACK_EN
    check("b2b_spacing", 32'(c1 + 1), 32'd12);
`else
    check("b2b_spacing", 32'(c1 + 1), 32'd13);
`endif
    bus.start = 1'b0;
    repeat (2 * W + 4) @(posedge clk);
    #1;
    check_idle("b2b_drained");
    held_cnt = W;

    // Asynchronous reset in the third SHIFT
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_shift", 32'(bus.shift), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("rst_mid_outs");
    check("rst_mid_cnt", 32'(bus.cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    check_idle("rst_mid_after");
    held_cnt = 0;
    repeat (2 * W + 4) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 32'(bus.done), 32'd0);
    end
    run_mul(5'd6, 5'b11101, 1'b0);

    // Randomised multiplies
    for (int i = 0; i < 1000; i++) begin
      run_mul(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
